// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter between an echo path (bytes from
// the receiver, buffered in a small FIFO) and a message source that uses a
// request/acknowledge handshake. A round-robin arbiter picks the next
// requester. A four-state controller hands each byte to the transmitter and
// follows the transmitter's ready/busy handshake. A busy-wait timeout stops
// the controller from hanging when the transmitter never reports busy.
`timescale 1ns/1ps

module uart_tx_arb #(
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [15:0] BUSY_TMO   = 16'd65535
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [7:0]            recv_data,
    input  logic                  vald_data,
    input  logic                  msg_req,
    input  logic [7:0]            msg_data,
    output logic                  msg_ack,
    input  logic                  tx_ready,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   fifo_cnt,
    output logic                  overflow,
    output logic                  tx_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(32'd1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(32'd1);
    localparam logic [15:0]           TMO_LAST = BUSY_TMO - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Controller state and registered outputs
    state_t                state_q;
    logic                  grant_msg_q;   // 1: current grant belongs to the message source
    logic                  prio_msg_q;    // 1: message source wins the next tie
    logic [15:0]           tmo_cnt_q;
    logic                  tx_send_q;
    logic                  msg_ack_q;
    logic [7:0]            tx_data_q;
    logic                  tx_err_q;

    // Echo FIFO storage and bookkeeping
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic [DEPTH_LOG2:0]   cnt_d;
    logic                  overflow_q;

    // Combinational helpers
    logic                  echo_req_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pick_msg_s;

    assign echo_req_s = (cnt_q != CNT_ZERO);
    assign full_s     = (cnt_q == CNT_FULL);
    // The FIFO head leaves only in SEND, and only if the grant went to echo.
    // The grant itself required a non-empty FIFO.
    assign pop_s      = (state_q == ST_SEND) && !grant_msg_q && echo_req_s;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_s     = vald_data && (!full_s || pop_s);
    assign drop_s     = vald_data && full_s && !pop_s;
    // The message source wins if it is alone or if it holds the priority.
    assign pick_msg_s = msg_req && (!echo_req_s || prio_msg_q);

    // Next occupancy from the push/pop pair
    always_comb begin
        cnt_d = cnt_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO data storage; the contents need no reset because occupancy guards every read
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= recv_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            cnt_q      <= CNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Arbitration, transmit handshake, timeout, and the registered strobe outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            grant_msg_q <= 1'b0;
            prio_msg_q  <= 1'b0;
            tmo_cnt_q   <= 16'd0;
            tx_send_q   <= 1'b0;
            msg_ack_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_err_q    <= 1'b0;
        end else begin
            tx_send_q <= 1'b0;
            msg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_cnt_q <= 16'd0;
                    if (tx_ready && (echo_req_s || msg_req)) begin
                        grant_msg_q <= pick_msg_s;
                        prio_msg_q  <= !pick_msg_s;
                        state_q     <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    tx_send_q <= 1'b1;
                    tmo_cnt_q <= 16'd0;
                    if (grant_msg_q) begin
                        tx_data_q <= msg_data;
                        msg_ack_q <= 1'b1;
                    end else begin
                        tx_data_q <= mem_q[rd_ptr_q];
                    end
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        tmo_cnt_q <= 16'd0;
                        state_q   <= ST_WAIT_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        // The transmitter never went busy: flag it and give up on this byte.
                        tx_err_q  <= 1'b1;
                        tmo_cnt_q <= 16'd0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                        state_q   <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    tmo_cnt_q <= 16'd0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_send  = tx_send_q;
    assign msg_ack  = msg_ack_q;
    assign tx_data  = tx_data_q;
    assign fifo_cnt = cnt_q;
    assign overflow = overflow_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb. It keeps a scoreboard of expected transmitted
// bytes and models a transmitter with selectable behaviour: held busy, held
// ready, or busy for a fixed time after each send. It also models a message
// source that drops its request on acknowledge.
`timescale 1ns/1ps

module tb_uart_tx_arb;

    typedef struct packed {
        logic [7:0] data;
        logic       is_msg;
    } exp_t;

    localparam int M_LOW  = 0;
    localparam int M_HIGH = 1;
    localparam int M_AUTO = 2;

    logic       CLK       = 1'b0;
    logic       RSTN      = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic       vald_data = 1'b0;
    logic       msg_req   = 1'b0;
    logic [7:0] msg_data  = 8'h00;
    logic       tx_ready  = 1'b0;
    logic       msg_ack;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [2:0] fifo_cnt;
    logic       overflow;
    logic       tx_err;

    int   total     = 0;
    int   bad       = 0;
    exp_t sb[$];
    int   sends     = 0;
    int   acks      = 0;
    int   cyc       = 0;
    int   last_send = -100;
    int   tx_mode   = M_LOW;
    int   busy_len  = 3;
    int   busy      = 0;

    uart_tx_arb #(
        .DEPTH_LOG2 (2),
        .BUSY_TMO   (16'd8)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .recv_data (recv_data),
        .vald_data (vald_data),
        .msg_req   (msg_req),
        .msg_data  (msg_data),
        .msg_ack   (msg_ack),
        .tx_ready  (tx_ready),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .tx_err    (tx_err)
    );

    always #5 CLK = ~CLK;

    // One clock: sample outputs after the edge, score sends, then update the transmitter/requester models.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (tx_send === 1'b1) begin
            sends++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: tx_send with tx_data=%h but no byte expected", tx_data);
            end else begin
                e = sb.pop_front();
                if (tx_data !== e.data || msg_ack !== e.is_msg) begin
                    bad++;
                    $display("FAIL sb_data: got data=%h ack=%b, expected data=%h ack=%b",
                             tx_data, msg_ack, e.data, e.is_msg);
                end
            end
            total++;
            if (cyc - last_send < 4) begin
                bad++;
                $display("FAIL send_spacing: got %0d cycles, expected >= 4", cyc - last_send);
            end
            last_send = cyc;
        end
        if (msg_ack === 1'b1) begin
            acks++;
            msg_req = 1'b0;
            total++;
            if (tx_send !== 1'b1) begin
                bad++;
                $display("FAIL ack_alone: msg_ack=1 with tx_send=%b, expected tx_send=1", tx_send);
            end
        end
        case (tx_mode)
            M_LOW:  tx_ready = 1'b0;
            M_HIGH: tx_ready = 1'b1;
            default: begin
                if (tx_send === 1'b1) begin
                    busy     = busy_len;
                    tx_ready = 1'b0;
                end else if (busy > 0) begin
                    busy--;
                    if (busy == 0) tx_ready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic push_byte(input logic [7:0] d);
        vald_data = 1'b1;
        recv_data = d;
        step();
        vald_data = 1'b0;
    endtask

    task automatic do_reset();
        RSTN      = 1'b0;
        vald_data = 1'b0;
        msg_req   = 1'b0;
        tx_mode   = M_LOW;
        tx_ready  = 1'b0;
        busy      = 0;
        step();
        step();
        sb.delete();
        last_send = -100;
        sends     = 0;
        acks      = 0;
        RSTN      = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({tx_send, msg_ack, tx_data, fifo_cnt, overflow, tx_err} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: send=%b ack=%b data=%h cnt=%0d ovf=%b err=%b, expected all 0",
                     tx_send, msg_ack, tx_data, fifo_cnt, overflow, tx_err);
        end
        step();
        step();
        RSTN = 1'b1;
        push_byte(8'h5A);
        total++;
        if (fifo_cnt !== 3'd1) begin
            bad++;
            $display("FAIL first_push: fifo_cnt=%0d, expected 1", fifo_cnt);
        end
    endtask

    task automatic test_echo();
        do_reset();
        tx_mode  = M_AUTO;
        busy_len = 10;
        tx_ready = 1'b1;
        sb.push_back('{8'h41, 1'b0});
        push_byte(8'h41);
        for (int i = 0; i < 60; i++) step();
        total++;
        if (sb.size() != 0 || sends != 1) begin
            bad++;
            $display("FAIL echo_sent: sends=%0d pending=%0d, expected 1 and 0", sends, sb.size());
        end
        total++;
        if (fifo_cnt !== 3'd0 || tx_data !== 8'h41) begin
            bad++;
            $display("FAIL echo_after: fifo_cnt=%0d tx_data=%h, expected 0 and 41", fifo_cnt, tx_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back('{8'(i + 1), 1'b0});
            push_byte(8'(i + 1));
        end
        total++;
        if (fifo_cnt !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_fill: fifo_cnt=%0d overflow=%b, expected 4 and 1", fifo_cnt, overflow);
        end
        tx_mode  = M_AUTO;
        busy_len = 3;
        tx_ready = 1'b1;
        for (int i = 0; i < 80; i++) step();
        total++;
        if (sb.size() != 0 || sends != 4 || fifo_cnt !== 3'd0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain: sends=%0d pending=%0d cnt=%0d ovf=%b, expected 4 0 0 1",
                     sends, sb.size(), fifo_cnt, overflow);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        sb.push_back('{8'hAA, 1'b0});
        sb.push_back('{8'h55, 1'b1});
        sb.push_back('{8'hBB, 1'b0});
        push_byte(8'hAA);
        push_byte(8'hBB);
        msg_data = 8'h55;
        msg_req  = 1'b1;
        step();
        tx_mode  = M_AUTO;
        busy_len = 3;
        tx_ready = 1'b1;
        for (int i = 0; i < 80; i++) step();
        total++;
        if (sb.size() != 0 || sends != 3 || acks != 1) begin
            bad++;
            $display("FAIL arb_order: sends=%0d acks=%0d pending=%0d, expected 3 1 0", sends, acks, sb.size());
        end
    endtask

    task automatic test_msg_withdraw();
        do_reset();
        msg_data = 8'h77;
        msg_req  = 1'b1;
        step();
        step();
        msg_req  = 1'b0;
        tx_mode  = M_AUTO;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (sends != 0 || acks != 0) begin
            bad++;
            $display("FAIL msg_withdraw: sends=%0d acks=%0d, expected 0 0", sends, acks);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tx_mode  = M_HIGH;
        tx_ready = 1'b1;
        sb.push_back('{8'h33, 1'b0});
        push_byte(8'h33);
        for (int i = 0; i < 20 && sends == 0; i++) step();
        total++;
        if (sends != 1) begin
            bad++;
            $display("FAIL tmo_send: sends=%0d, expected 1 within 20 cycles", sends);
        end
        repeat (7) step();
        total++;
        if (tx_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early: tx_err=%b at cycle 7, expected 0", tx_err);
        end
        step();
        total++;
        if (tx_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_flag: tx_err=%b at cycle 8, expected 1", tx_err);
        end
        tx_mode  = M_AUTO;
        busy_len = 3;
        sb.push_back('{8'h66, 1'b0});
        push_byte(8'h66);
        for (int i = 0; i < 40; i++) step();
        total++;
        if (sb.size() != 0 || sends != 2 || tx_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_recover: sends=%0d pending=%0d err=%b, expected 2 0 1", sends, sb.size(), tx_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb.push_back('{8'hC1, 1'b0});
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        tx_mode  = M_AUTO;
        busy_len = 50;
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && sends == 0; i++) step();
        step();
        step();
        total++;
        if (sends != 1 || fifo_cnt !== 3'd2) begin
            bad++;
            $display("FAIL mid_setup: sends=%0d fifo_cnt=%0d, expected 1 and 2", sends, fifo_cnt);
        end
        #3;
        RSTN = 1'b0;
        #1;
        total++;
        if ({tx_send, msg_ack, tx_data, fifo_cnt, overflow, tx_err} !== 15'd0) begin
            bad++;
            $display("FAIL mid_reset: send=%b ack=%b data=%h cnt=%0d ovf=%b err=%b, expected all 0",
                     tx_send, msg_ack, tx_data, fifo_cnt, overflow, tx_err);
        end
        step();
        sb.delete();
        sends     = 0;
        last_send = -100;
        busy      = 0;
        RSTN      = 1'b1;
        tx_ready  = 1'b1;
        for (int i = 0; i < 30; i++) step();
        total++;
        if (sends != 0) begin
            bad++;
            $display("FAIL mid_quiet: sends=%0d after reset release, expected 0", sends);
        end
        busy_len = 3;
        sb.push_back('{8'hD4, 1'b0});
        push_byte(8'hD4);
        for (int i = 0; i < 30; i++) step();
        total++;
        if (sends != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL mid_new: sends=%0d pending=%0d, expected 1 0", sends, sb.size());
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{8'(8'h10 + i), 1'b0});
            push_byte(8'(8'h10 + i));
        end
        tx_mode  = M_AUTO;
        busy_len = 3;
        tx_ready = 1'b1;
        step();
        sb.push_back('{8'h14, 1'b0});
        push_byte(8'h14);
        total++;
        if (fifo_cnt !== 3'd4 || overflow !== 1'b0 || sends != 1) begin
            bad++;
            $display("FAIL full_pushpop: cnt=%0d ovf=%b sends=%0d, expected 4 0 1", fifo_cnt, overflow, sends);
        end
        for (int i = 0; i < 100; i++) step();
        total++;
        if (sb.size() != 0 || fifo_cnt !== 3'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_drain: pending=%0d cnt=%0d ovf=%b, expected 0 0 0", sb.size(), fifo_cnt, overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_mode  = M_AUTO;
        busy_len = 1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{8'(8'hE0 + i), 1'b0});
            push_byte(8'(8'hE0 + i));
        end
        for (int i = 0; i < 40; i++) step();
        total++;
        if (sends != 3 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_sent: sends=%0d pending=%0d, expected 3 0", sends, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_overflow();
        test_arbitration();
        test_msg_withdraw();
        test_timeout();
        test_reset_mid();
        test_full_pushpop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
